// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the R1/R2/R3/AR + 16-word memory datapath; ADD/SUB/STORE retire 3 cycles after accept, LOAD 4.
// One instruction in flight: instr_ready is high only in IDLE, so the source holds instr until it is accepted.
module datapath_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             l1,
  output logic             l2,
  output logic             l3,
  output logic             l4,
  output logic [2:0]       s1,
  output logic [2:0]       s2,
  output logic             f,
  output logic             w,
  output logic             r,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {IDLE, DECODE, MEMRD, EXEC, DONE} state_t;

  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_t     state;
  logic [1:0] op;
  logic [1:0] dst;

  // Outputs are registered on the edge that enters a state, so they describe the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= 2'b00;
      dst         <= 2'b00;
      instr_ready <= 1'b0;
      {l4, l3, l2, l1} <= 4'b0000;
      s1          <= 3'd0;
      s2          <= 3'd0;
      f           <= 1'b0;
      w           <= 1'b0;
      r           <= 1'b0;
      done        <= 1'b0;
      retired     <= '0;
    end else begin
      {l4, l3, l2, l1} <= 4'b0000;
      w    <= 1'b0;
      r    <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            instr_ready <= 1'b0;
            op          <= instr[9:8];
            dst         <= instr[7:6];
            if (instr[9:8] == OP_LOAD) begin
              s1 <= 3'd3;
              s2 <= 3'd5;
              f  <= 1'b0;
            end else begin
              s1 <= instr[5:3];
              s2 <= instr[2:0];
              f  <= (instr[9:8] == OP_SUB);
            end
            state <= DECODE;
          end
        end
        DECODE: begin
          if (op == OP_LOAD) begin
            r     <= 1'b1;
            state <= MEMRD;
          end else begin
            if (op == OP_STORE) w <= 1'b1;
            else                {l4, l3, l2, l1} <= 4'b0001 << dst;
            state <= EXEC;
          end
        end
        MEMRD: begin
          // Memory read stays enabled while the destination register captures it.
          r                <= 1'b1;
          {l4, l3, l2, l1} <= 4'b0001 << dst;
          state            <= EXEC;
        end
        EXEC: begin
          done    <= 1'b1;
          retired <= retired + CNT_W'(1);
          state   <= DONE;
        end
        DONE: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: table of instructions with hand-computed selects/strobes, plus reset/abort and counter-wrap sequences.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       l1, l2, l3, l4;
  logic [2:0] s1, s2;
  logic       f, w, r, done;
  logic [7:0] retired;

  datapath_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .l1(l1), .l2(l2), .l3(l3), .l4(l4),
    .s1(s1), .s2(s2), .f(f), .w(w), .r(r), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ins;
    logic [2:0] es1;
    logic [2:0] es2;
    logic       ef;
    logic [3:0] elm;   // expected {l4,l3,l2,l1}
    logic       ew;
    logic       ld;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_ret = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 20 && instr_ready !== 1'b1; n++) step();
    chk("wait_ready", 32'(instr_ready), 32'd1);
  endtask

  function automatic logic [7:0] ctl();
    return {instr_ready, l4, l3, l2, l1, w, r, done};
  endfunction

  // Cycle 1 = DECODE; strobe at lat-1; done at lat; ready again at lat+1.
  task automatic run_instr(input int idx, input vec_t v, input logic [9:0] nxt, input bit have_next);
    int         lat;
    logic [7:0] exp_ctl;
    lat = v.ld ? 4 : 3;
    wait_ready();
    instr       = v.ins;
    instr_valid = 1'b1;
    step();
    if (have_next) instr = nxt;
    else           instr_valid = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      if (c > 1) step();
      exp_ctl = {(c == lat + 1), ((c == lat - 1) ? v.elm : 4'b0000), ((c == lat - 1) && v.ew),
                 (v.ld && (c == 2 || c == 3)), (c == lat)};
      chk($sformatf("ctl v%0d c%0d", idx, c), 32'(ctl()), 32'(exp_ctl));
      chk($sformatf("sel v%0d c%0d", idx, c), 32'({s1, s2, f}), 32'({v.es1, v.es2, v.ef}));
      if (c == lat) begin
        exp_ret++;
        chk($sformatf("retired v%0d", idx), 32'(retired), 32'(exp_ret));
      end
    end
  endtask

  vec_t tbl[7];

  initial begin
    int dones, lcnt, other, ovl, badgap, last;

    tbl[0] = '{10'b00_01_001_000, 3'd1, 3'd0, 1'b0, 4'b0010, 1'b0, 1'b0}; // ADD R2 <= R1 + x
    tbl[1] = '{10'b01_11_100_001, 3'd4, 3'd1, 1'b1, 4'b1000, 1'b0, 1'b0}; // SUB AR <= R3 - R1
    tbl[2] = '{10'b10_00_010_101, 3'd2, 3'd5, 1'b0, 4'b0000, 1'b1, 1'b0}; // STORE M[AR] <= R2 + 0
    tbl[3] = '{10'b11_10_000_000, 3'd3, 3'd5, 1'b0, 4'b0100, 1'b0, 1'b1}; // LOAD R3 <= M[AR]
    tbl[4] = '{10'b00_00_010_101, 3'd2, 3'd5, 1'b0, 4'b0001, 1'b0, 1'b0}; // MOV R1 <= R2
    tbl[5] = '{10'b11_11_111_110, 3'd3, 3'd5, 1'b0, 4'b1000, 1'b0, 1'b1}; // LOAD AR, srcs ignored
    tbl[6] = '{10'b01_01_111_100, 3'd7, 3'd4, 1'b1, 4'b0010, 1'b0, 1'b0}; // SUB R2 <= 0 - R3

    // Reset held three cycles with a valid instruction present.
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = tbl[0].ins;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset ctl %0d", i), 32'(ctl()), 32'd0);
      chk($sformatf("reset sel %0d", i), 32'({s1, s2, f}), 32'd0);
      chk($sformatf("reset retired %0d", i), 32'(retired), 32'd0);
    end
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    step();
    chk("release ready", 32'(ctl()), 32'h80);

    // Table run: all back-to-back with valid held, last one drops valid.
    for (int i = 0; i < 7; i++)
      run_instr(i, tbl[i], (i < 6) ? tbl[i + 1].ins : 10'd0, i < 6);

    // Idle with no request: stays ready, selects keep the last instruction's values.
    step();
    step();
    chk("idle ctl", 32'(ctl()), 32'h80);
    chk("idle sel hold", 32'({s1, s2, f}), 32'({3'd7, 3'd4, 1'b1}));

    // Reset during the MEMRD cycle of a LOAD aborts it.
    wait_ready();
    instr       = tbl[3].ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("abort memrd r", 32'(ctl()), 32'h02);
    rst_n = 1'b0;
    step();
    chk("abort reset ctl", 32'(ctl()), 32'd0);
    chk("abort retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    other = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (l1 | l2 | l3 | l4 | w | r | done) other++;
    end
    chk("abort no strobes after", 32'(other), 32'd0);
    chk("abort idle ready", 32'(instr_ready), 32'd1);
    chk("abort retired stays 0", 32'(retired), 32'd0);

    // 256 consecutive ADD R1 <= R1 + R2: counter wraps, spacing 4 cycles.
    instr       = 10'b00_00_001_010;
    instr_valid = 1'b1;
    dones = 0; lcnt = 0; other = 0; ovl = 0; badgap = 0; last = -1;
    for (int cyc = 0; cyc < 3000 && dones < 256; cyc++) begin
      step();
      if (w && (l1 | l2 | l3 | l4)) ovl++;
      if (l1) lcnt++;
      if (l2 | l3 | l4 | w | r) other++;
      if (done) begin
        dones++;
        if (last >= 0 && cyc - last != 4) badgap++;
        last = cyc;
        if (dones == 255) chk("retired 255", 32'(retired), 32'd255);
        if (dones == 256) chk("retired wrap", 32'(retired), 32'd0);
      end
    end
    instr_valid = 1'b0;
    chk("wrap done count", 32'(dones), 32'd256);
    chk("wrap l1 count", 32'(lcnt), 32'd256);
    chk("wrap stray strobes", 32'(other), 32'd0);
    chk("wrap w/l overlap", 32'(ovl), 32'd0);
    chk("wrap done spacing", 32'(badgap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
